mem_arbiter: RTL and testbench

Shares a single-port backing memory between the fetch stage's instruction port and the memory stage's data port, so the core can run from one unified instruction/data memory. The block sits between the pipeline and the memory model. It arbitrates with data-side priority and a starvation guard for fetch. It sequences one outstanding transaction at a time and routes each response back to its owner.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arb_prio.sv | 39 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified I/D memory arbiter: FSM states, owner tags and
// the default fetch-starvation limit.
package mem_arb_pkg;

  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between pipeline ports, the arbiter and the backing memory.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                    i_req;
  logic [ADDR_WIDTH-1:0]   i_addr;
  logic                    i_gnt;
  logic                    i_rvalid;
  logic [DATA_WIDTH-1:0]   i_rdata;

  logic                    d_req;
  logic                    d_we;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic                    d_gnt;
  logic                    d_rvalid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  logic                    m_req;
  logic                    m_we;
  logic [DATA_WIDTH/8-1:0] m_be;
  logic [ADDR_WIDTH-1:0]   m_addr;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic                    m_ready;
  logic                    m_rvalid;
  logic [DATA_WIDTH-1:0]   m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner select for the arbiter: data side wins unless fetch has lost
// STARVE_LIMIT consecutive contested grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic sel_i,
  output logic sel_d
);

  localparam int unsigned     CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Counter only advances on data grants that actually made fetch wait.
  always_comb begin
    sel_i    = grant_en & i_req & (~d_req | (starve_q == LIMIT));
    sel_d    = grant_en & d_req & ~sel_i;
    starve_d = starve_q;
    if (sel_i) begin
      starve_d = '0;
    end else if (sel_d && i_req && (starve_q != LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Unified I/D single-port memory arbiter, one outstanding transaction at a time.
// Define MEM_ARB_PERF_EN to add the perf_i_wait/perf_d_wait stall counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_i_wait,
  output logic [31:0] perf_d_wait
`endif
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [BE_WIDTH-1:0]   m_be_q, m_be_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic                  i_rvalid_q, i_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  grant_en, sel_i, sel_d;

  assign grant_en = (state_q == IDLE);

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .i_req    (bus.i_req),
    .d_req    (bus.d_req),
    .grant_en (grant_en),
    .sel_i    (sel_i),
    .sel_d    (sel_d)
  );

  // Transaction sequencer: latch winner, issue, wait for response, return it.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (sel_i) begin
          owner_d   = OWN_I;
          m_we_d    = 1'b0;
          m_be_d    = '1;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
          m_req_d   = 1'b1;
          state_d   = ISSUE;
        end else if (sel_d) begin
          owner_d   = OWN_D;
          m_we_d    = bus.d_we;
          m_be_d    = bus.d_be;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_req_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          m_req_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_rvalid) begin
          state_d = RESP;
          if (owner_q == OWN_I) begin
            i_rdata_d  = bus.m_rdata;
            i_rvalid_d = 1'b1;
          end else begin
            // Writes are acknowledged with zero data.
            d_rdata_d  = m_we_q ? '0 : bus.m_rdata;
            d_rvalid_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.i_gnt    = sel_i;
  assign bus.d_gnt    = sel_d;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_be     = m_be_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_i_d, perf_d_q, perf_d_d;

  // Cycles each side spends requesting without being granted; wraps.
  always_comb begin
    perf_i_d = perf_i_q + 32'(bus.i_req & ~sel_i);
    perf_d_d = perf_d_q + 32'(bus.d_req & ~sel_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
    end
  end

  assign perf_i_wait = perf_i_q;
  assign perf_d_wait = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory payloads
// and responses; a memory model and a response monitor pop and compare.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_wait, perf_d_wait;
`endif

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_wait (perf_i_wait),
    .perf_d_wait (perf_d_wait)
`endif
  );

  typedef struct packed {
    logic          own_d;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct packed {
    logic          full;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } memx_t;

  resp_t sb_q[$];
  memx_t mx_q[$];
  logic  glog[$];
  int    checks = 0;
  int    passes = 0;
  int    rv_total = 0;
  int    ready_delay = 0;
  int    rvalid_delay = 0;
  logic  inject_rv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  task automatic push_resp(input logic own_d, input logic [DW-1:0] data);
    resp_t r;
    r.own_d = own_d;
    r.data  = data;
    sb_q.push_back(r);
  endtask

  task automatic push_mx(input logic full, input logic we, input logic [3:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    memx_t m;
    m.full = full; m.we = we; m.be = be; m.addr = addr; m.wdata = wdata;
    mx_q.push_back(m);
  endtask

  // Memory model: programmable accept and response delays.
  initial begin : mem_model
    int rdy_cnt;
    int rv_cnt;
    logic pending;
    logic seen;
    logic [AW-1:0] acc_addr;
    logic [AW-1:0] first_addr;
    memx_t e;
    rdy_cnt = 0; rv_cnt = 0; pending = 1'b0; seen = 1'b0;
    acc_addr = '0; first_addr = '0;
    bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      bus.m_ready  = 1'b0;
      bus.m_rvalid = 1'b0;
      if (!rst) begin
        pending = 1'b0; seen = 1'b0; rdy_cnt = 0;
      end else if (pending) begin
        if (rv_cnt < rvalid_delay) rv_cnt++;
        else begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = mem_fn(acc_addr);
          pending      = 1'b0;
        end
      end else if (inject_rv) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'hBAD0BAD0;
      end else if (bus.m_req) begin
        if (!seen) begin seen = 1'b1; first_addr = bus.m_addr; end
        if (rdy_cnt < ready_delay) rdy_cnt++;
        else begin
          bus.m_ready = 1'b1;
          acc_addr = bus.m_addr;
          pending = 1'b1; rv_cnt = 0; rdy_cnt = 0; seen = 1'b0;
          chk("m_addr_stable", 64'(acc_addr), 64'(first_addr));
          if (mx_q.size() == 0) chk("unexpected_m_req", 64'(mx_q.size()), 64'(1));
          else begin
            e = mx_q.pop_front();
            chk("m_we", 64'(bus.m_we), 64'(e.we));
            chk("m_addr", 64'(bus.m_addr), 64'(e.addr));
            if (e.full) begin
              chk("m_be", 64'(bus.m_be), 64'(e.be));
              chk("m_wdata", 64'(bus.m_wdata), 64'(e.wdata));
            end
          end
        end
      end
    end
  end

  // Response monitor and grant logger.
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (bus.i_gnt || bus.d_gnt) begin
          chk("gnt_exclusive", 64'(bus.i_gnt & bus.d_gnt), 64'(0));
          glog.push_back(bus.d_gnt);
        end
        if (bus.i_rvalid || bus.d_rvalid) begin
          rv_total++;
          chk("rvalid_exclusive", 64'(bus.i_rvalid & bus.d_rvalid), 64'(0));
          if (sb_q.size() == 0) chk("unexpected_rvalid", 64'(sb_q.size()), 64'(1));
          else begin
            e = sb_q.pop_front();
            chk("resp_owner", 64'(bus.d_rvalid), 64'(e.own_d));
            chk("resp_data", bus.d_rvalid ? 64'(bus.d_rdata) : 64'(bus.i_rdata), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic wait_gnt(input logic want_d, input string tag);
    int n = 0;
    forever begin
      @(negedge clk);
      if (want_d ? bus.d_gnt : bus.i_gnt) break;
      n++;
      if (n > 60) begin
        chk({tag, "_gnt_timeout"}, 64'(n), 64'(0));
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drain"}, 64'(sb_q.size()), 64'(0));
  endtask

  task automatic count_mreq(input string tag, input logic [AW-1:0] addr, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.m_req || n > 40) break;
      n++;
      chk({tag, "_m_addr_held"}, 64'(bus.m_addr), 64'(addr));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({bus.m_req, bus.m_we, bus.m_be, bus.i_rvalid, bus.d_rvalid}), 64'(0));
    chk({tag, "_m_addr"}, 64'(bus.m_addr), 64'(0));
    chk({tag, "_m_wdata"}, 64'(bus.m_wdata), 64'(0));
    chk({tag, "_i_rdata"}, 64'(bus.i_rdata), 64'(0));
    chk({tag, "_d_rdata"}, 64'(bus.d_rdata), 64'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic exp_ord [10];
    int n;
    int rv0;
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_gnt", 64'({bus.i_gnt, bus.d_gnt}), 64'(0));
    @(posedge clk); #1 rst = 1'b1;

    // Lone fetch with cycle-exact latency
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    push_resp(1'b0, 32'hDEADBEEF);
    push_mx(1'b0, 1'b0, 4'h0, 32'h100, 32'h0);
    @(negedge clk); chk("lone_i_gnt_c0", 64'(bus.i_gnt), 64'(1));
    @(posedge clk); #1 bus.i_req = 1'b0;
    @(negedge clk);
    chk("lone_m_req_c1", 64'(bus.m_req), 64'(1));
    chk("lone_m_addr_c1", 64'(bus.m_addr), 64'(32'h100));
    @(negedge clk);
    @(negedge clk);
    chk("lone_i_rvalid_c3", 64'(bus.i_rvalid), 64'(1));
    chk("lone_i_rdata_c3", 64'(bus.i_rdata), 64'(32'hDEADBEEF));
    drain("lone");

    // Data write: zero read data on the acknowledge
    push_resp(1'b1, 32'h0);
    push_mx(1'b1, 1'b1, 4'b0011, 32'h2000, 32'h1234);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
    bus.d_addr = 32'h2000; bus.d_wdata = 32'h1234;
    wait_gnt(1'b1, "wr");
    @(posedge clk); #1 bus.d_req = 1'b0; bus.d_we = 1'b0;
    drain("wr");

    // Both sides held: starvation guard lets fetch in every fifth grant
    glog.delete();
    for (int k = 0; k < 10; k++) begin
      if (exp_ord[k]) begin
        push_resp(1'b1, 32'hFFFFCFFF);
        push_mx(1'b1, 1'b0, 4'hF, 32'h3000, 32'h0);
      end else begin
        push_resp(1'b0, 32'hDEADBEEF);
        push_mx(1'b0, 1'b0, 4'h0, 32'h100, 32'h0);
      end
    end
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h3000; bus.d_wdata = '0;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if (glog.size() >= 10 || n > 80) break;
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    chk("order_grant_count", 64'(glog.size()), 64'(10));
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk($sformatf("order_grant_%0d", k), 64'(glog[k]), 64'(exp_ord[k]));
    drain("order");

    // Memory backpressure; payload changes after grant must not leak through
    ready_delay = 3; rvalid_delay = 5;
    rv0 = rv_total;
    push_resp(1'b1, 32'hFFFFBFFF);
    push_mx(1'b1, 1'b0, 4'hF, 32'h4000, 32'h0);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h4000;
    wait_gnt(1'b1, "bp");
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_addr = 32'h9999; bus.d_we = 1'b1;
    count_mreq("bp", 32'h4000, n);
    chk("bp_m_req_cycles", 64'(n), 64'(4));
    drain("bp");
    repeat (3) @(posedge clk);
    chk("bp_single_rvalid", 64'(rv_total - rv0), 64'(1));
    bus.d_we = 1'b0;
    ready_delay = 0; rvalid_delay = 8;

    // Reset during WAIT abandons the fetch; stale m_rvalid is ignored
    push_resp(1'b0, 32'hFFFFFAFF);
    push_mx(1'b0, 1'b0, 4'h0, 32'h500, 32'h0);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    wait_gnt(1'b0, "rst");
    @(posedge clk); #1 bus.i_req = 1'b0;
    count_mreq("rst", 32'h500, n);
    @(posedge clk); #2;
    rst = 1'b0;
    sb_q.delete();
    mx_q.delete();
    #1;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rvalid_delay = 0;
    rv0 = rv_total;
    @(posedge clk); #1 inject_rv = 1'b1;
    @(posedge clk); #1 inject_rv = 1'b0;
    repeat (4) @(posedge clk);
    chk("rst_stale_rvalid_ignored", 64'(rv_total - rv0), 64'(0));
    chk("rst_i_rdata_kept_zero", 64'(bus.i_rdata), 64'(0));
    push_resp(1'b0, 32'hDEADBEEF);
    push_mx(1'b0, 1'b0, 4'h0, 32'h100, 32'h0);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    wait_gnt(1'b0, "post_rst");
    @(posedge clk); #1 bus.i_req = 1'b0;
    drain("post_rst");

`ifdef MEM_ARB_PERF_EN
    // Fetch blocked behind a stalled data read for six cycles
    ready_delay = 2;
    push_resp(1'b1, 32'hFFFFCFFF);
    push_mx(1'b1, 1'b0, 4'hF, 32'h3000, 32'h0);
    push_resp(1'b0, 32'hDEADBEEF);
    push_mx(1'b0, 1'b0, 4'h0, 32'h100, 32'h0);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h3000;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    wait_gnt(1'b1, "perf_d");
    @(posedge clk); #1 bus.d_req = 1'b0;
    wait_gnt(1'b0, "perf_i");
    chk("perf_i_wait", 64'(perf_i_wait), 64'(6));
    chk("perf_d_wait", 64'(perf_d_wait), 64'(0));
    @(posedge clk); #1 bus.i_req = 1'b0;
    drain("perf");
    ready_delay = 0;
`endif

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
